// File: rtl/tinyml_complex_soc_pkg.sv
// Shared types and AXI constants for the cycle probe: FSM encoding, operation kinds,
// counter width and the fixed single-beat burst attributes.
package tinyml_complex_soc_pkg;

  localparam int COUNT_WIDTH = 48;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B
  } state_t;

  typedef enum logic [1:0] {
    OP_START,
    OP_STOP,
    OP_CLEAR
  } op_t;

endpackage

// File: rtl/tinyml_complex_soc_cycle_probe.sv
// Measures t1-t0 of a remote 48-bit counter via single-beat AXI4 reads; clear writes 0.
// arvalid/awvalid follow the trigger by one cycle; one transaction in flight, triggers while busy are dropped.
module tinyml_complex_soc_cycle_probe
  import tinyml_complex_soc_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int PROBE_ID       = 0,
  parameter int COUNTER_ADDR   = 0
) (
  input  logic                          i_clk,
  input  logic                          i_resetn,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_clear,
  output logic                          o_busy,
  output logic                          o_armed,
  output logic [COUNT_WIDTH-1:0]        o_delta,
  output logic                          o_delta_valid,
  output logic                          o_drop,
  output logic                          o_err,
  output logic                          o_axi4initiator_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0]     o_axi4initiator_araddr,
  output logic [AXI_ID_WIDTH-1:0]       o_axi4initiator_arid,
  output logic [7:0]                    o_axi4initiator_arlen,
  output logic [2:0]                    o_axi4initiator_arsize,
  output logic [1:0]                    o_axi4initiator_arburst,
  input  logic                          i_axi4initiator_arready,
  input  logic                          i_axi4initiator_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0]     i_axi4initiator_rdata,
  input  logic [AXI_ID_WIDTH-1:0]       i_axi4initiator_rid,
  input  logic                          i_axi4initiator_rlast,
  input  logic [1:0]                    i_axi4initiator_rresp,
  output logic                          o_axi4initiator_rready,
  output logic                          o_axi4initiator_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]     o_axi4initiator_awaddr,
  output logic [AXI_ID_WIDTH-1:0]       o_axi4initiator_awid,
  output logic [7:0]                    o_axi4initiator_awlen,
  output logic [2:0]                    o_axi4initiator_awsize,
  output logic [1:0]                    o_axi4initiator_awburst,
  input  logic                          i_axi4initiator_awready,
  output logic                          o_axi4initiator_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]     o_axi4initiator_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_axi4initiator_wstrb,
  output logic                          o_axi4initiator_wlast,
  input  logic                          i_axi4initiator_wready,
  input  logic                          i_axi4initiator_bvalid,
  input  logic [AXI_ID_WIDTH-1:0]       i_axi4initiator_bid,
  input  logic [1:0]                    i_axi4initiator_bresp,
  output logic                          o_axi4initiator_bready
);

  localparam logic [AXI_ID_WIDTH-1:0]   ID   = AXI_ID_WIDTH'(PROBE_ID);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR = AXI_ADDR_WIDTH'(COUNTER_ADDR);

  state_t state, state_nxt;
  op_t    op, op_nxt;
  logic   drop_nxt;
  logic   aw_done, w_done;
  logic   armed;
  logic [COUNT_WIDTH-1:0] t0;

  logic r_fire, r_ok, b_fire, b_ok;
  logic any_trig;

  logic unused_bits;
  assign unused_bits = ^{i_axi4initiator_rlast, i_axi4initiator_rdata[AXI_DATA_WIDTH-1:COUNT_WIDTH]};

  assign any_trig = i_start | i_stop | i_clear;
  assign r_fire   = (state == ST_R) && i_axi4initiator_rvalid;
  assign r_ok     = r_fire && (i_axi4initiator_rresp == 2'b00) && (i_axi4initiator_rid == ID);
  assign b_fire   = (state == ST_B) && i_axi4initiator_bvalid;
  assign b_ok     = b_fire && (i_axi4initiator_bresp == 2'b00) && (i_axi4initiator_bid == ID);

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    drop_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        // clear > stop (only meaningful while armed) > start
        if (i_clear) begin
          state_nxt = ST_AWW;
          op_nxt    = OP_CLEAR;
          drop_nxt  = i_start | (i_stop & armed);
        end else if (i_stop && armed) begin
          state_nxt = ST_AR;
          op_nxt    = OP_STOP;
          drop_nxt  = i_start;
        end else if (i_start) begin
          state_nxt = ST_AR;
          op_nxt    = OP_START;
        end
      end
      ST_AR: begin
        drop_nxt = any_trig;
        if (i_axi4initiator_arready) state_nxt = ST_R;
      end
      ST_R: begin
        drop_nxt = any_trig;
        if (i_axi4initiator_rvalid) state_nxt = ST_IDLE;
      end
      ST_AWW: begin
        drop_nxt = any_trig;
        if ((aw_done || i_axi4initiator_awready) && (w_done || i_axi4initiator_wready))
          state_nxt = ST_B;
      end
      ST_B: begin
        drop_nxt = any_trig;
        if (i_axi4initiator_bvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= ST_IDLE;
      op    <= OP_START;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      armed         <= 1'b0;
      t0            <= '0;
      o_delta       <= '0;
      o_delta_valid <= 1'b0;
      o_drop        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      // AW and W are accepted independently; remember which one already went
      aw_done       <= (state == ST_AWW) && (state_nxt == ST_AWW) && (aw_done || i_axi4initiator_awready);
      w_done        <= (state == ST_AWW) && (state_nxt == ST_AWW) && (w_done || i_axi4initiator_wready);
      o_drop        <= drop_nxt;
      o_err         <= (r_fire && !r_ok) || (b_fire && !b_ok);
      o_delta_valid <= r_ok && (op == OP_STOP);
      if (r_ok && op == OP_START) begin
        t0    <= i_axi4initiator_rdata[COUNT_WIDTH-1:0];
        armed <= 1'b1;
      end
      if (r_ok && op == OP_STOP) begin
        o_delta <= i_axi4initiator_rdata[COUNT_WIDTH-1:0] - t0;
        armed   <= 1'b0;
      end
      if (b_ok && op == OP_CLEAR) armed <= 1'b0;
    end
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_armed = armed;

  assign o_axi4initiator_arvalid = (state == ST_AR);
  assign o_axi4initiator_araddr  = ADDR;
  assign o_axi4initiator_arid    = ID;
  assign o_axi4initiator_arlen   = AXI_LEN_SINGLE;
  assign o_axi4initiator_arsize  = AXI_SIZE_8B;
  assign o_axi4initiator_arburst = AXI_BURST_INCR;
  assign o_axi4initiator_rready  = (state == ST_R);

  assign o_axi4initiator_awvalid = (state == ST_AWW) && !aw_done;
  assign o_axi4initiator_awaddr  = ADDR;
  assign o_axi4initiator_awid    = ID;
  assign o_axi4initiator_awlen   = AXI_LEN_SINGLE;
  assign o_axi4initiator_awsize  = AXI_SIZE_8B;
  assign o_axi4initiator_awburst = AXI_BURST_INCR;
  assign o_axi4initiator_wvalid  = (state == ST_AWW) && !w_done;
  assign o_axi4initiator_wdata   = '0;
  assign o_axi4initiator_wstrb   = '1;
  assign o_axi4initiator_wlast   = 1'b1;
  assign o_axi4initiator_bready  = (state == ST_B);

endmodule

// File: tb/tb_tinyml_complex_soc_cycle_probe.sv
// Directed bench for the cycle probe: AXI target with a counter model, transaction-level reference model.
module tb_tinyml_complex_soc_cycle_probe;

  localparam int DW = 64;
  localparam int IW = 5;
  localparam int AW = 8;
  localparam int PROBE_ID_P = 5;
  localparam int COUNTER_ADDR_P = 8'h40;
  localparam logic [IW-1:0] PID = 5'd5;
  localparam logic [AW-1:0] PADDR = 8'h40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic i_start = 1'b0, i_stop = 1'b0, i_clear = 1'b0;
  logic o_busy, o_armed, o_delta_valid, o_drop, o_err;
  logic [47:0] o_delta;

  logic          arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [AW-1:0] araddr, awaddr;
  logic [IW-1:0] arid, awid;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;

  logic          arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [IW-1:0] rid = '0, bid = '0;
  logic [1:0]    rresp = 2'b00, bresp = 2'b00;

  tinyml_complex_soc_cycle_probe #(
    .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW),
    .PROBE_ID(PROBE_ID_P), .COUNTER_ADDR(COUNTER_ADDR_P)
  ) dut (
    .i_clk(clk), .i_resetn(rst_n),
    .i_start(i_start), .i_stop(i_stop), .i_clear(i_clear),
    .o_busy(o_busy), .o_armed(o_armed), .o_delta(o_delta),
    .o_delta_valid(o_delta_valid), .o_drop(o_drop), .o_err(o_err),
    .o_axi4initiator_arvalid(arvalid), .o_axi4initiator_araddr(araddr),
    .o_axi4initiator_arid(arid), .o_axi4initiator_arlen(arlen),
    .o_axi4initiator_arsize(arsize), .o_axi4initiator_arburst(arburst),
    .i_axi4initiator_arready(arready),
    .i_axi4initiator_rvalid(rvalid), .i_axi4initiator_rdata(rdata),
    .i_axi4initiator_rid(rid), .i_axi4initiator_rlast(rlast),
    .i_axi4initiator_rresp(rresp), .o_axi4initiator_rready(rready),
    .o_axi4initiator_awvalid(awvalid), .o_axi4initiator_awaddr(awaddr),
    .o_axi4initiator_awid(awid), .o_axi4initiator_awlen(awlen),
    .o_axi4initiator_awsize(awsize), .o_axi4initiator_awburst(awburst),
    .i_axi4initiator_awready(awready),
    .o_axi4initiator_wvalid(wvalid), .o_axi4initiator_wdata(wdata),
    .o_axi4initiator_wstrb(wstrb), .o_axi4initiator_wlast(wlast),
    .i_axi4initiator_wready(wready),
    .i_axi4initiator_bvalid(bvalid), .i_axi4initiator_bid(bid),
    .i_axi4initiator_bresp(bresp), .o_axi4initiator_bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // target configuration, written only by the stimulus block
  int ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic [1:0] rresp_cfg = 2'b00;
  logic r_stall = 1'b0;
  logic [47:0] counter_val = '0;

  // target state and event counters, written only by the negedge process
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  bit prev_ar_wait = 0;
  logic [AW-1:0] prev_araddr = '0;
  int aw_beats = 0, w_beats = 0, b_beats = 0, ar_hi = 0;
  int dv_count = 0, drop_count = 0, err_count = 0;
  logic [DW-1:0] last_wdata = '1;

  // reference model: transaction-level view of the probe
  bit m_busy = 0, m_armed = 0;
  int m_op = 0; // 0 start read, 1 stop read, 2 clear write
  logic [47:0] m_t0 = '0, m_delta = '0;
  bit e_dv = 0, e_err = 0, e_drop = 0, e_ar = 0, e_aww = 0;

  always @(negedge clk) begin
    bit hs_r, hs_ar, hs_aw, hs_w, hs_b, ok;
    if (!rst_n) begin
      m_busy = 0; m_armed = 0; m_t0 = '0; m_delta = '0;
      e_dv = 0; e_err = 0; e_drop = 0; e_ar = 0; e_aww = 0;
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; prev_ar_wait = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      chk("reset_handshake", {arvalid, rready, awvalid, wvalid, bready}, 0);
      chk("reset_status", {o_busy, o_armed, o_delta_valid, o_drop, o_err, o_delta}, 0);
    end else begin
      chk("busy", o_busy, m_busy);
      chk("armed", o_armed, m_armed);
      chk("delta", o_delta, m_delta);
      chk("delta_valid", o_delta_valid, e_dv);
      chk("drop", o_drop, e_drop);
      chk("err", o_err, e_err);
      if (e_ar) chk("arvalid_after_trigger", arvalid, 1);
      if (e_aww) chk("aw_w_after_clear", {awvalid, wvalid}, 2'b11);
      if (arvalid) chk("ar_fields", {araddr, arid, arlen, arsize, arburst}, {PADDR, PID, 8'd0, 3'd3, 2'b01});
      if (awvalid) chk("aw_fields", {awaddr, awid, awlen, awsize, awburst}, {PADDR, PID, 8'd0, 3'd3, 2'b01});
      if (wvalid) chk("w_fields", {wlast, wstrb}, {1'b1, 8'hFF});
      if (prev_ar_wait) chk("ar_stable", {arvalid, araddr}, {1'b1, prev_araddr});
      if (o_delta_valid) dv_count++;
      if (o_drop) drop_count++;
      if (o_err) err_count++;
      if (arvalid) ar_hi++;

      rvalid = r_pend && !r_stall;
      rdata  = {16'hBEEF, counter_val};
      rresp  = rresp_cfg;
      rid    = PID;
      rlast  = 1'b1;
      hs_r   = rvalid && rready;

      if (arvalid) begin arready = (ar_cnt >= ar_delay); if (!arready) ar_cnt++; end
      else begin arready = 0; ar_cnt = 0; end
      hs_ar = arvalid && arready;
      if (hs_ar) ar_cnt = 0;
      prev_ar_wait = arvalid && !arready;
      prev_araddr  = araddr;

      if (awvalid) begin awready = (aw_cnt >= aw_delay); if (!awready) aw_cnt++; end
      else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_delay); if (!wready) w_cnt++; end
      else begin wready = 0; w_cnt = 0; end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;

      bvalid = b_pend;
      bid    = PID;
      bresp  = 2'b00;
      hs_b   = bvalid && bready;

      if (hs_r) r_pend = 0;
      if (hs_ar) r_pend = 1;
      if (hs_aw) begin aw_beats++; aw_got = 1; aw_cnt = 0; end
      if (hs_w) begin w_beats++; w_got = 1; w_cnt = 0; last_wdata = wdata; end
      if (hs_b) begin b_pend = 0; b_beats++; end
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end

      e_dv = 0; e_err = 0; e_drop = 0; e_ar = 0; e_aww = 0;
      if (!m_busy) begin
        if (i_clear) begin
          m_busy = 1; m_op = 2; e_aww = 1; e_drop = i_start || (i_stop && m_armed);
        end else if (i_stop && m_armed) begin
          m_busy = 1; m_op = 1; e_ar = 1; e_drop = i_start;
        end else if (i_start) begin
          m_busy = 1; m_op = 0; e_ar = 1;
        end
      end else begin
        e_drop = i_start || i_stop || i_clear;
        if (m_op != 2 && hs_r) begin
          ok = (rresp == 2'b00) && (rid == PID);
          if (!ok) e_err = 1;
          else if (m_op == 0) begin m_t0 = rdata[47:0]; m_armed = 1; end
          else begin m_delta = rdata[47:0] - m_t0; e_dv = 1; m_armed = 0; end
          m_busy = 0;
        end
        if (m_op == 2 && hs_b) begin
          m_armed = 0;
          m_busy = 0;
        end
      end
    end
  end

  task automatic pulse(input logic s, input logic p, input logic c);
    @(posedge clk); #1;
    i_start = s; i_stop = p; i_clear = c;
    @(posedge clk); #1;
    i_start = 0; i_stop = 0; i_clear = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: actual busy after 200 cycles, required idle");
  endtask

  initial begin
    int dv0, dr0, er0, aw0, w0, b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // basic measurement
    dv0 = dv_count;
    counter_val = 48'd1000; pulse(1, 0, 0); wait_idle();
    chk("basic_armed", o_armed, 1);
    counter_val = 48'd1500; pulse(0, 1, 0); wait_idle();
    chk("basic_delta", o_delta, 48'd500);
    chk("basic_dv_once", dv_count - dv0, 1);
    chk("basic_disarmed", o_armed, 0);

    // stop while not armed is ignored silently
    dr0 = drop_count;
    pulse(0, 1, 0); repeat (2) @(posedge clk); #1;
    chk("stop_unarmed_idle", {o_busy, 32'(drop_count - dr0)}, 0);

    // counter wrap
    counter_val = 48'hFFFF_FFFF_FFF0; pulse(1, 0, 0); wait_idle();
    counter_val = 48'h10; pulse(0, 1, 0); wait_idle();
    chk("wrap_delta", o_delta, 48'h20);

    // backpressure: AR stalled 5 cycles, W 3 cycles after AW
    ar_delay = 5; ar_hi = 0;
    counter_val = 48'd42; pulse(1, 0, 0); wait_idle();
    chk("ar_valid_cycles", ar_hi, 6);
    chk("bp_armed", o_armed, 1);
    ar_delay = 0; w_delay = 3;
    aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
    pulse(0, 0, 1); wait_idle();
    chk("bp_aw_beats", aw_beats - aw0, 1);
    chk("bp_w_beats", w_beats - w0, 1);
    chk("bp_b_beats", b_beats - b0, 1);
    chk("bp_wdata", last_wdata, 0);
    chk("bp_clear_disarms", o_armed, 0);
    w_delay = 0;

    // start during an outstanding read is dropped, t0 kept
    ar_delay = 3; dr0 = drop_count;
    counter_val = 48'd2000; pulse(1, 0, 0);
    counter_val = 48'd9999; pulse(1, 0, 0);
    counter_val = 48'd2000; wait_idle();
    ar_delay = 0;
    chk("mid_read_drop", drop_count - dr0, 1);
    counter_val = 48'd2100; pulse(0, 1, 0); wait_idle();
    chk("mid_read_t0_kept", o_delta, 48'd100);

    // clear + start together: write of 0, one drop
    counter_val = 48'd300; pulse(1, 0, 0); wait_idle();
    dr0 = drop_count; w0 = w_beats; last_wdata = '1;
    pulse(1, 0, 1); wait_idle();
    chk("clr_start_drop", drop_count - dr0, 1);
    chk("clr_start_write", {32'(w_beats - w0), last_wdata[31:0]}, {32'd1, 32'd0});
    chk("clr_start_disarm", o_armed, 0);

    // error response on a stop read
    counter_val = 48'd5000; pulse(1, 0, 0); wait_idle();
    dv0 = dv_count; er0 = err_count;
    rresp_cfg = 2'd2; counter_val = 48'd5300; pulse(0, 1, 0); wait_idle();
    rresp_cfg = 2'd0;
    chk("err_pulse", err_count - er0, 1);
    chk("err_no_dv", dv_count - dv0, 0);
    chk("err_armed_kept", o_armed, 1);
    chk("err_delta_kept", o_delta, 48'd100);

    // reset while the read data is outstanding
    r_stall = 1; counter_val = 48'd7000; pulse(1, 0, 0);
    for (int i = 0; i < 50 && !rready; i++) @(negedge clk);
    chk("reached_r", rready, 1);
    @(posedge clk); #1 rst_n = 0;
    #1;
    chk("rst_now_rready", rready, 0);
    chk("rst_now_arvalid", arvalid, 0);
    chk("rst_now_armed", o_armed, 0);
    repeat (2) @(posedge clk);
    #1 r_stall = 0; rst_n = 1;
    counter_val = 48'd7000; pulse(1, 0, 0); wait_idle();
    chk("after_rst_armed", o_armed, 1);
    counter_val = 48'd7250; pulse(0, 1, 0); wait_idle();
    chk("after_rst_delta", o_delta, 48'd250);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinyml_complex_soc_cycle_probe.md
TINYML_COMPLEX_SOC_CYCLE_PROBE -- requirements
Module: tinyml_complex_soc_cycle_probe

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning AXI4 data bus width.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 5, meaning AXI4 ID width.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 8, meaning AXI4 address width.
REQ-004 SHALL have parameter PROBE_ID, default 0, meaning ID driven on AR/AW and expected on R/B.
REQ-005 SHALL have parameter COUNTER_ADDR, default 0, meaning byte address of the 48-bit counter target.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: i_clk and i_resetn.
REQ-007 SHALL have port i_clk, input, 1 bit: the block's only clock.
REQ-008 SHALL have port i_resetn, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port i_start, input, 1 bit: one-cycle pulse that captures start timestamp t0.
REQ-010 SHALL have port i_stop, input, 1 bit: one-cycle pulse that captures stop timestamp t1.
REQ-011 SHALL have port i_clear, input, 1 bit: one-cycle pulse that writes 0 to the counter.
REQ-012 SHALL have port o_busy, output, 1 bit: an AXI transaction is in flight.
REQ-013 SHALL have port o_armed, output, 1 bit: t0 is held and a stop is pending.
REQ-014 SHALL have port o_delta, output, 48 bits: last measured t1-t0.
REQ-015 SHALL have port o_delta_valid, output, 1 bit: one-cycle pulse when o_delta updates.
REQ-016 SHALL have port o_drop, output, 1 bit: one-cycle pulse when a trigger is ignored because the block is busy.
REQ-017 SHALL have port o_err, output, 1 bit: one-cycle pulse when a response has resp!=0 or an ID mismatch.
REQ-018 SHALL have the AR channel ports: o_axi4initiator_arvalid/araddr/arid/arlen/arsize/arburst, outputs; i_axi4initiator_arready, input.
REQ-019 SHALL have the R channel ports: i_axi4initiator_rvalid/rdata/rid/rlast/rresp, inputs; o_axi4initiator_rready, output.
REQ-020 SHALL have the AW and W channel ports: o_axi4initiator_awvalid/awaddr/awid/awlen/awsize/awburst and o_axi4initiator_wvalid/wdata/wstrb/wlast, outputs; i_axi4initiator_awready and i_axi4initiator_wready, inputs.
REQ-021 SHALL have the B channel ports: i_axi4initiator_bvalid/bid/bresp, inputs; o_axi4initiator_bready, output.

Function
REQ-022 SHALL issue only single-beat transactions: len=0, size=3 (8 bytes), burst=INCR, addr=COUNTER_ADDR, id=PROBE_ID, wlast=1, wstrb all ones.
REQ-023 SHALL implement the states IDLE, AR, R, AWW and B.
REQ-024 SHALL go IDLE->AR on an accepted i_start, or on i_stop while armed; arvalid SHALL assert the cycle after the trigger.
REQ-025 SHALL go IDLE->AWW on i_clear, with wdata=0 and awvalid and wvalid asserted together the next cycle.
REQ-026 SHALL give same-cycle triggers in IDLE the priority clear > stop > start; the lower-priority triggers SHALL be dropped, each pulsing o_drop.
REQ-027 SHALL hold arvalid and araddr stable until arready (AR->R), and SHALL hold rready=1 in state R.
REQ-028 SHALL hold awvalid until awready and wvalid until wready, each independently; AWW->B SHALL occur once both have been accepted, including the same cycle.
REQ-029 SHALL hold bready=1 in state B; on bvalid it SHALL return to IDLE.
REQ-030 SHALL, on an R beat that completes a start read, latch t0=rdata[47:0] and set armed=1; rdata[63:48] SHALL be ignored.
REQ-031 SHALL, on an R beat that completes a stop read, set o_delta=(rdata[47:0]-t0) mod 2^48, pulse o_delta_valid and clear armed; counter wrap SHALL give the modular delta.
REQ-032 SHALL clear armed when a clear write completes.
REQ-033 SHALL ignore i_stop in IDLE while not armed, with no o_drop pulse.
REQ-034 SHALL treat i_start in IDLE while armed as a re-arm that overwrites t0.
REQ-035 SHALL ignore a trigger received in any non-IDLE state and pulse o_drop.
REQ-036 SHALL, when resp!=0 or rid/bid!=PROBE_ID, still complete the handshake, pulse o_err, and neither update t0/o_delta nor change armed.
REQ-037 SHALL drive o_busy=1 in every state except IDLE.

Reset
REQ-038 SHALL, on i_resetn=0, immediately force state IDLE, all valid/ready outputs 0, o_delta=0, t0=0, armed=0 and all pulses 0, including mid-transaction.
REQ-039 SHALL restart from IDLE after reset is released, with no memory of any transaction abandoned by the reset.

Structure
REQ-040 SHALL place the state encoding, the operation-kind enum (START/STOP/CLEAR), COUNT_WIDTH=48 and the AXI constants (size, burst) in a shared package, tinyml_complex_soc_pkg.
REQ-041 SHALL be a single module with no sub-module.

Verification
REQ-042 SHALL verify a basic measurement: a target counter model, start with rdata=1000, then stop with rdata=1500 -> o_delta=500, one o_delta_valid pulse, armed=0.
REQ-043 SHALL verify wrap: t0=0xFFFF_FFFF_FFF0, t1=0x10 -> o_delta=0x20.
REQ-044 SHALL verify backpressure: arready low for 5 cycles, then awready accepted 3 cycles before wready -> arvalid held and stable, exactly one AW and one W beat, then one B.
REQ-045 SHALL verify triggers during a transaction: i_start issued mid-read -> o_drop pulse and t0 unchanged; clear+start in the same cycle -> write of 0 and one o_drop pulse.
REQ-046 SHALL verify an error response: rresp=2 on a stop read -> o_err pulse, no o_delta_valid, armed stays 1.
REQ-047 SHALL verify reset mid-operation: i_resetn asserted in state R -> rready and arvalid 0 immediately, armed=0, next start completes normally.
